// File: rtl/niveles_mascota_pkg.sv
// Shared constants, level encodings and the saturating step used by niveles_mascota
// and consumed downstream by fms_estado.
package niveles_mascota_pkg;

  localparam logic [2:0] NIVEL_MAX     = 3'd5;
  localparam logic [2:0] NIVEL_MIN     = 3'd0;
  localparam logic [2:0] HAMBRE_RST    = 3'd0;
  localparam logic [2:0] DIVERSION_RST = 3'd3;

  // Level codes as fms_estado reads them; N_MUERTO on hambre is the death state.
  typedef enum logic [2:0] {
    N_CERO   = 3'd0,
    N_UNO    = 3'd1,
    N_DOS    = 3'd2,
    N_TRES   = 3'd3,
    N_CUATRO = 3'd4,
    N_MUERTO = 3'd5
  } nivel_e;

  // One step up or down, clamped to [NIVEL_MIN, tope]; simultaneous up+down cancel.
  function automatic logic [2:0] nivel_sig(input logic [2:0] n, input logic sube,
                                           input logic baja, input logic [2:0] tope);
    nivel_sig = n;
    if (sube && !baja && n < tope)             nivel_sig = n + 3'd1;
    else if (baja && !sube && n != NIVEL_MIN)  nivel_sig = n - 3'd1;
  endfunction

endpackage

// File: rtl/niveles_mascota_detector_flanco.sv
// Raw button to one-cycle pulse: 2-FF synchroniser, delay flop, rising-edge detect.
// A button already held when reset is released must be let go before it can pulse.
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulso
);
  logic       s1, s2, s3;
  logic       armado;
  logic [1:0] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      vld_pipe <= '0;
      armado   <= 1'b0;
    end else begin
      s1       <= btn;
      s2       <= s1;
      s3       <= s2;
      vld_pipe <= {vld_pipe[0], 1'b1};
      // s2 only reflects the pin once the pipe has filled; arm on the first real low.
      armado   <= armado | (vld_pipe[1] & ~s2);
    end
  end

  assign pulso = s2 & ~s3 & armado;

endmodule

// File: rtl/niveles_mascota.sv
// Need-level generator for fms_estado: hunger rises / fun falls with time,
// buttons move them back; both freeze once hunger saturates (death) until reset.
module niveles_mascota #(
  parameter int TICK_HAMBRE    = 50_000_000,
  parameter int TICK_DIVERSION = 75_000_000,
  parameter int ACCEL          = 10,
  parameter int NIVEL_MAX      = int'(niveles_mascota_pkg::NIVEL_MAX)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_comer,
  input  logic       btn_jugar,
  input  logic       ultrasonido,
  input  logic       acelerar,
  output logic [2:0] hambre,
  output logic [2:0] diversion,
  output logic       muerto
);
  import niveles_mascota_pkg::*;

  localparam int WH = (TICK_HAMBRE    > 1) ? $clog2(TICK_HAMBRE)    : 1;
  localparam int WD = (TICK_DIVERSION > 1) ? $clog2(TICK_DIVERSION) : 1;
  localparam logic [WH-1:0] H_FIN_N = WH'(TICK_HAMBRE - 1);
  localparam logic [WH-1:0] H_FIN_A = WH'(TICK_HAMBRE / ACCEL - 1);
  localparam logic [WD-1:0] D_FIN_N = WD'(TICK_DIVERSION - 1);
  localparam logic [WD-1:0] D_FIN_A = WD'(TICK_DIVERSION / ACCEL - 1);
  localparam logic [2:0]    TOPE    = 3'(NIVEL_MAX);

  logic [1:0] btns, pulsos;
  assign btns = {btn_jugar, btn_comer};

  for (genvar i = 0; i < 2; i++) begin : g_det
    detector_flanco u_det (
      .clk   (clk),
      .rst_n (reset),
      .btn   (btns[i]),
      .pulso (pulsos[i])
    );
  end

  // Prescalers: a mode switch restarts both from zero and swallows that cycle's tick.
  logic          acel_q, cambio;
  logic [WH-1:0] cnt_h, h_fin;
  logic [WD-1:0] cnt_d, d_fin;
  logic          tick_h, tick_d;

  assign cambio = acelerar ^ acel_q;
  assign h_fin  = acel_q ? H_FIN_A : H_FIN_N;
  assign d_fin  = acel_q ? D_FIN_A : D_FIN_N;
  assign tick_h = ~cambio & (cnt_h == h_fin);
  assign tick_d = ~cambio & (cnt_d == d_fin);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acel_q <= 1'b0;
      cnt_h  <= '0;
      cnt_d  <= '0;
    end else begin
      acel_q <= acelerar;
      cnt_h  <= (cambio || cnt_h == h_fin) ? '0 : cnt_h + WH'(1);
      cnt_d  <= (cambio || cnt_d == d_fin) ? '0 : cnt_d + WD'(1);
    end
  end

  logic [2:0] h_sig, d_sig;

  always_comb begin
    h_sig = hambre;
    d_sig = diversion;
    if (!muerto) begin
      h_sig = nivel_sig(hambre,    tick_h,                   pulsos[0], TOPE);
      d_sig = nivel_sig(diversion, pulsos[1] & ultrasonido,  tick_d,    TOPE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hambre    <= HAMBRE_RST;
      diversion <= DIVERSION_RST;
      muerto    <= 1'b0;
    end else begin
      hambre    <= h_sig;
      diversion <= d_sig;
      muerto    <= (h_sig == TOPE);
    end
  end

endmodule

// File: tb/tb_niveles_mascota.sv
// Directed bench for niveles_mascota with short prescaler periods (8 / 12, ACCEL 4).
module tb_niveles_mascota;
  logic       clk = 1'b0;
  logic       reset, btn_comer, btn_jugar, ultrasonido, acelerar;
  logic [2:0] hambre, diversion;
  logic       muerto;

  niveles_mascota #(
    .TICK_HAMBRE    (8),
    .TICK_DIVERSION (12),
    .ACCEL          (4),
    .NIVEL_MAX      (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_comer   (btn_comer),
    .btn_jugar   (btn_jugar),
    .ultrasonido (ultrasonido),
    .acelerar    (acelerar),
    .hambre      (hambre),
    .diversion   (diversion),
    .muerto      (muerto)
  );

  always #5 clk = ~clk;

  // e: edge index after reset release; c/j/u/a are driven after checking h/d/m at that edge.
  typedef struct {
    int         e;
    logic       c, j, u, a;
    logic [2:0] h, d;
    logic       m;
  } vec_t;

  vec_t tabla[$];
  int   ntest = 0;
  int   nfail = 0;
  int   e     = 0;

  function automatic vec_t fila(int fe, int c, int j, int u, int a, int h, int d, int m);
    vec_t r;
    r.e = fe; r.c = c[0]; r.j = j[0]; r.u = u[0]; r.a = a[0];
    r.h = h[2:0]; r.d = d[2:0]; r.m = m[0];
    return r;
  endfunction

  task automatic chk(input string nombre, input logic [2:0] eh, input logic [2:0] ed,
                     input logic em);
    ntest++;
    if (hambre !== eh || diversion !== ed || muerto !== em) begin
      nfail++;
      $display("FAIL %s: got hambre=%0d diversion=%0d muerto=%0d, expected hambre=%0d diversion=%0d muerto=%0d",
               nombre, hambre, diversion, muerto, eh, ed, em);
    end
  endtask

  task automatic paso();
    @(posedge clk);
    e++;
    #1;
  endtask

  initial begin
    //                 e  c j u a  h d m
    tabla.push_back(fila( 3, 1,0,0,0, 0,3,0));
    tabla.push_back(fila( 4, 0,1,0,0, 0,3,0));
    tabla.push_back(fila( 5, 0,0,0,0, 0,3,0));
    tabla.push_back(fila( 6, 0,0,0,0, 0,3,0));
    tabla.push_back(fila( 7, 0,0,1,0, 0,3,0));
    tabla.push_back(fila( 8, 0,0,1,0, 1,3,0));
    tabla.push_back(fila( 9, 0,0,1,0, 1,3,0));
    tabla.push_back(fila(11, 0,0,1,0, 1,3,0));
    tabla.push_back(fila(12, 0,1,1,0, 1,2,0));
    tabla.push_back(fila(13, 0,0,1,0, 1,2,0));
    tabla.push_back(fila(14, 0,1,1,0, 1,2,0));
    tabla.push_back(fila(15, 0,0,1,0, 1,3,0));
    tabla.push_back(fila(16, 0,1,1,0, 2,3,0));
    tabla.push_back(fila(17, 1,0,1,0, 2,4,0));
    tabla.push_back(fila(18, 0,1,1,0, 2,4,0));
    tabla.push_back(fila(19, 0,0,1,0, 2,5,0));
    tabla.push_back(fila(20, 0,1,1,0, 1,5,0));
    tabla.push_back(fila(21, 0,0,1,0, 1,5,0));
    tabla.push_back(fila(22, 1,0,1,0, 1,5,0));
    tabla.push_back(fila(23, 1,0,1,0, 1,5,0));
    tabla.push_back(fila(24, 1,0,1,0, 2,4,0));
    tabla.push_back(fila(25, 1,0,1,0, 1,4,0));
    tabla.push_back(fila(32, 1,0,1,0, 2,4,0));
    tabla.push_back(fila(36, 1,0,1,0, 2,3,0));
    tabla.push_back(fila(40, 1,0,1,0, 3,3,0));
    tabla.push_back(fila(42, 0,0,1,0, 3,3,0));
    tabla.push_back(fila(45, 1,0,1,0, 3,3,0));
    tabla.push_back(fila(46, 0,0,1,0, 3,3,0));
    tabla.push_back(fila(47, 0,0,1,0, 3,3,0));
    tabla.push_back(fila(48, 0,0,1,0, 3,2,0));
    tabla.push_back(fila(49, 0,0,1,1, 3,2,0));
    tabla.push_back(fila(50, 0,0,1,1, 3,2,0));
    tabla.push_back(fila(52, 0,0,1,1, 4,2,0));
    tabla.push_back(fila(53, 0,0,1,1, 4,1,0));
    tabla.push_back(fila(54, 1,1,1,1, 5,1,1));
    tabla.push_back(fila(55, 0,0,1,1, 5,1,1));
    tabla.push_back(fila(57, 0,0,1,1, 5,1,1));
    tabla.push_back(fila(60, 0,0,1,1, 5,1,1));

    reset = 1'b0; btn_comer = 1'b0; btn_jugar = 1'b0; ultrasonido = 1'b0; acelerar = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("reset_c%0d", k), 3'd0, 3'd3, 1'b0);
    end
    reset = 1'b1;
    e = 0;

    for (int i = 0; i < tabla.size(); i++) begin
      while (e < tabla[i].e) paso();
      chk($sformatf("E%0d", tabla[i].e), tabla[i].h, tabla[i].d, tabla[i].m);
      btn_comer   = tabla[i].c;
      btn_jugar   = tabla[i].j;
      ultrasonido = tabla[i].u;
      acelerar    = tabla[i].a;
    end

    // Dead and mid-prescale: reset must act without waiting for an edge.
    #3;
    reset = 1'b0; btn_comer = 1'b1; btn_jugar = 1'b0; acelerar = 1'b1;
    #1;
    chk("reset_async", 3'd0, 3'd3, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_held", 3'd0, 3'd3, 1'b0);
    reset = 1'b1;
    e = 0;

    // Held comer must not pulse; had it, it would cancel the first fast tick at edge 3.
    while (e < 3) paso();
    chk("held_E3", 3'd1, 3'd3, 1'b0);
    paso();
    chk("held_E4", 3'd1, 3'd2, 1'b0);
    paso();
    chk("held_E5", 3'd2, 3'd2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
